spinner: RTL and testbench

Top-level demo block driving the 8-digit seven-segment display: a short lit "snake" of segments runs around the outer perimeter of the display. Switches control reset, run/hold, direction, tail length and speed. LEDs optionally echo status. It sits directly under the board top, on the 100 MHz clock.

---
 rtl/spinner_pkg.sv | 59 +++++
 rtl/spinner_tick.sv | 38 +++
 rtl/spinner.sv | 105 ++++++++++
 tb/tb_spinner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/spinner_pkg.sv
// Shared types and helpers for the perimeter spinner: position encoding,
// segment bit indices and position-to-(digit, segment) mapping.
`timescale 1ns/1ps
package spinner_pkg;

    localparam int NUM_POS = 20;

    typedef logic [4:0] pos_t;

    // Bit indices into an active-low segment vector {G,F,E,D,C,B,A}.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef struct packed {
        logic [2:0] digit;
        logic [2:0] seg;
    } seg_loc_t;

    function automatic seg_loc_t pos_to_seg(input pos_t p);
        seg_loc_t r;
        r.digit = 3'd0;
        r.seg   = 3'(SEG_A);
        if (p < 5'd8) begin
            r.digit = 3'd7 - p[2:0];
            r.seg   = 3'(SEG_A);
        end else if (p == 5'd8) begin
            r.digit = 3'd0;
            r.seg   = 3'(SEG_B);
        end else if (p == 5'd9) begin
            r.digit = 3'd0;
            r.seg   = 3'(SEG_C);
        end else if (p < 5'd18) begin
            r.digit = 3'(p - 5'd10);
            r.seg   = 3'(SEG_D);
        end else if (p == 5'd18) begin
            r.digit = 3'd7;
            r.seg   = 3'(SEG_E);
        end else begin
            r.digit = 3'd7;
            r.seg   = 3'(SEG_F);
        end
        return r;
    endfunction

    function automatic pos_t pos_wrap_inc(input pos_t p);
        return (p == 5'(NUM_POS - 1)) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic pos_t pos_wrap_dec(input pos_t p);
        return (p == 5'd0) ? 5'(NUM_POS - 1) : p - 5'd1;
    endfunction

endpackage

// File: rtl/spinner_tick.sv
// Run-gated step prescaler: period is STEP_CYCLES >> speed (minimum 1);
// emits a one-cycle step pulse and clears on the same edge.
`timescale 1ns/1ps
module spinner_tick #(
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic [2:0] i_speed,
    output logic       o_step
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_period;
    logic             w_tc;

    always_comb begin
        w_period = 32'(STEP_CYCLES) >> i_speed;
        if (w_period == 32'd0) w_period = 32'd1;
        // >= rather than == so a faster speed never strands the count above the period
        w_tc = (32'(r_cnt) >= (w_period - 32'd1));
    end

    assign o_step = i_run && w_tc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_run) begin
            if (w_tc) r_cnt <= '0;
            else      r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spinner.sv
// Seven-segment perimeter "snake" demo. Optional status echo on LED is
// enabled by defining SPINNER_LED_STATUS_EN.
`timescale 1ns/1ps
module spinner
    import spinner_pkg::*;
#(
    parameter int STEP_CYCLES  = 25_000_000,
    parameter int REFRESH_BITS = 17
) (
    input  logic        CLK100MHZ,
    input  logic [15:0] SW,
    output logic [15:0] LED,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic [7:0]  AN
);

    logic                    w_rst;
    logic                    w_run;
    logic                    w_ccw;
    logic [1:0]              w_tail;
    logic [2:0]              w_speed;
    logic                    w_step;
    logic [2:0]              w_digit;
    logic [6:0]              w_seg_n;
    logic                    w_unused;

    pos_t                    r_head;
    logic [REFRESH_BITS-1:0] r_scan;
    logic [7:0]              r_an;
    logic [6:0]              r_seg_n;
    logic [15:0]             r_led;

    assign w_rst    = SW[2];
    assign w_run    = SW[1];
    assign w_ccw    = SW[0];
    assign w_tail   = SW[4:3];
    assign w_speed  = SW[15:13];
    assign w_unused = &{1'b0, SW[12:5]};
    assign w_digit  = r_scan[REFRESH_BITS-1 -: 3];

    spinner_tick #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_tick (
        .i_clk   (CLK100MHZ),
        .i_rst   (w_rst),
        .i_run   (w_run),
        .i_speed (w_speed),
        .o_step  (w_step)
    );

    // Walk from the head backwards against the motion, lighting up to 4 taps.
    always_comb begin
        pos_t     w_tap;
        seg_loc_t w_loc;
        w_seg_n = SEG_OFF;
        w_tap   = r_head;
        w_loc   = '0;
        for (int k = 0; k < 4; k++) begin
            if (k <= int'(w_tail)) begin
                w_loc = pos_to_seg(w_tap);
                if (w_loc.digit == w_digit) w_seg_n[w_loc.seg] = 1'b0;
            end
            w_tap = w_ccw ? pos_wrap_inc(w_tap) : pos_wrap_dec(w_tap);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (w_rst) begin
            r_head  <= '0;
            r_scan  <= '0;
            r_an    <= 8'hFF;
            r_seg_n <= SEG_OFF;
            r_led   <= '0;
        end else begin
            if (w_step) r_head <= w_ccw ? pos_wrap_dec(r_head) : pos_wrap_inc(r_head);
            r_scan  <= r_scan + 1'b1;
            r_an    <= ~(8'd1 << w_digit);
            r_seg_n <= w_seg_n;
`ifdef SPINNER_LED_STATUS_EN
            r_led   <= {w_run, w_ccw, w_step, 6'b0, w_tail, r_head};
`else
            r_led   <= '0;
`endif
        end
    end

    assign AN  = r_an;
    assign CA  = r_seg_n[SEG_A];
    assign CB  = r_seg_n[SEG_B];
    assign CC  = r_seg_n[SEG_C];
    assign CD  = r_seg_n[SEG_D];
    assign CE  = r_seg_n[SEG_E];
    assign CF  = r_seg_n[SEG_F];
    assign CG  = r_seg_n[SEG_G];
    assign DP  = 1'b1;
    assign LED = r_led;

endmodule

// File: tb/tb_spinner.sv
// Self-checking bench for spinner with STEP_CYCLES=4, REFRESH_BITS=3:
// directed scenarios followed by random switch settings against a model.
`timescale 1ns/1ps
module tb_spinner;

    localparam int STEP = 4;
    localparam int RB   = 3;

    logic        clk = 1'b0;
    logic [15:0] sw;
    logic [15:0] led;
    logic        ca, cb, cc, cd, ce, cf, cg, dp;
    logic [7:0]  an;

    int compared   = 0;
    int mismatched = 0;

    int          m_head = 0;
    int          m_cnt  = 0;
    int          m_scan = 0;
    logic [7:0]  e_an   = 8'hFF;
    logic [6:0]  e_seg  = 7'h7F;
    logic [15:0] e_led  = 16'h0000;

    always #5 clk = ~clk;

    spinner #(
        .STEP_CYCLES  (STEP),
        .REFRESH_BITS (RB)
    ) dut (
        .CLK100MHZ (clk),
        .SW        (sw),
        .LED       (led),
        .CA        (ca),
        .CB        (cb),
        .CC        (cc),
        .CD        (cd),
        .CE        (ce),
        .CF        (cf),
        .CG        (cg),
        .DP        (dp),
        .AN        (an)
    );

    // Returns digit*8 + segment index (A=0 .. F=5) for a perimeter position.
    function automatic int pos_map(input int p);
        int dig, seg;
        if (p < 8)       begin dig = 7 - p;  seg = 0;      end
        else if (p < 10) begin dig = 0;      seg = p - 7;  end
        else if (p < 18) begin dig = p - 10; seg = 3;      end
        else             begin dig = 7;      seg = p - 14; end
        return dig * 8 + seg;
    endfunction

    task automatic model_edge();
        int  d, len, p, code, per;
        bit  step;
        if (sw[2]) begin
            m_head = 0; m_cnt = 0; m_scan = 0;
            e_an = 8'hFF; e_seg = 7'h7F; e_led = 16'h0000;
        end else begin
            d = m_scan;
            e_an = 8'hFF;
            e_an[d] = 1'b0;
            e_seg = 7'h7F;
            len = int'(sw[4:3]) + 1;
            for (int k = 0; k < len; k++) begin
                p = sw[0] ? (m_head + k) % 20 : (m_head - k + 20) % 20;
                code = pos_map(p);
                if (code / 8 == d) e_seg[code % 8] = 1'b0;
            end
            per = STEP >> sw[15:13];
            if (per < 1) per = 1;
            step = 1'b0;
            if (sw[1]) begin
                if (m_cnt >= per - 1) begin step = 1'b1; m_cnt = 0; end
                else m_cnt = m_cnt + 1;
            end
`ifdef SPINNER_LED_STATUS_EN
            e_led = {sw[1], sw[0], step, 6'b0, sw[4:3], 5'(m_head)};
`else
            e_led = 16'h0000;
`endif
            if (step) m_head = sw[0] ? (m_head + 19) % 20 : (m_head + 1) % 20;
            m_scan = (m_scan + 1) % 8;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".an"},  {8'h00, an}, {8'h00, e_an});
        chk({tag, ".seg"}, {9'h000, cg, cf, ce, cd, cc, cb, ca}, {9'h000, e_seg});
        chk({tag, ".dp"},  {15'h0000, dp}, 16'h0001);
        chk({tag, ".led"}, led, e_led);
    endtask

    task automatic run_n(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        sw = 16'h0004;
        @(negedge clk);
        run_n("reset", 2);
        sw = 16'h0000;
        run_n("post_reset", 10);

        // clockwise, tail 1, full lap and a bit
        sw = 16'h0002;
        run_n("cw_run", 90);

        // hold for 3 cycles then resume
        sw = 16'h0000;
        run_n("hold", 3);
        sw = 16'h0002;
        run_n("resume", 12);

        // counter-clockwise from head 0
        sw = 16'h0004;
        run_n("ccw_rst", 1);
        sw = 16'h0003;
        run_n("ccw_run", 20);

        // tail of 4, clockwise up to head 2, then freeze and scan all digits
        sw = 16'h0004;
        run_n("tail_rst", 1);
        sw = 16'h001A;
        run_n("tail_run", 8);
        sw = 16'h0018;
        run_n("tail_hold", 16);

        // speed change with counter at 3
        sw = 16'h0004;
        run_n("spd_rst", 1);
        sw = 16'h0002;
        run_n("spd_slow", 3);
        sw = 16'h4002;
        run_n("spd_fast", 12);

        // mid-run reset
        sw = 16'h0006;
        run_n("mid_rst", 1);
        sw = 16'h0002;
        run_n("after_mid_rst", 6);

        // random switch settings, occasionally reset
        for (int blk = 0; blk < 120; blk++) begin
            sw = 16'($urandom);
            sw[2] = ($urandom_range(0, 31) == 0);
            run_n("random", $urandom_range(1, 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
